// File: rtl/eb1_dec_trigger_csr.sv
// Decode-side debug trigger CSR block: mtsel/mtdata1/mtdata2 storage,
// trigger packet generation, pair chaining and registered halt/exception requests.

package eb1_trig_pkg;
    typedef struct packed {
        logic        select;
        logic        match;
        logic        store;
        logic        load;
        logic        execute;
        logic        m;
        logic [31:0] tdata2;
    } eb1_trigger_pkt_t;
endpackage

module eb1_dec_trigger_csr #(
    parameter int NTRIG   = 4,
    parameter int MASKMAX = 31
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     dbg_mode,
    input  logic                                     mstatus_mie,
    input  logic                                     csr_wen,
    input  logic [11:0]                              csr_waddr,
    input  logic [31:0]                              csr_wdata,
    input  logic [11:0]                              csr_raddr,
    output logic [31:0]                              csr_rdata,
    input  logic [NTRIG-1:0]                         trigger_match_m,
    input  logic                                     trigger_valid_m,
    output eb1_trig_pkg::eb1_trigger_pkt_t [NTRIG-1:0] trigger_pkt_any,
    output logic [NTRIG-1:0]                         trigger_hit_vec_r,
    output logic                                     trigger_dbg_r,
    output logic                                     trigger_exc_r
);

    localparam logic [11:0] ADDR_MTSEL   = 12'h7A0;
    localparam logic [11:0] ADDR_MTDATA1 = 12'h7A1;
    localparam logic [11:0] ADDR_MTDATA2 = 12'h7A2;

    logic [1:0]             mtsel_reg;
    logic [NTRIG-1:0]       dmode_vec, hit_vec, select_vec, action_vec, chain_vec;
    logic [NTRIG-1:0]       match_vec, m_vec, execute_vec, store_vec, load_vec;
    logic [NTRIG-1:0][31:0] tdata2_vec;
    logic [NTRIG-1:0]       raw, fire;
    logic                   lock, wr_tsel, wr_tdata1, wr_tdata2;
    logic                   dbg_next, exc_next;

    // A trigger owned by debug mode cannot be modified from normal mode.
    assign lock      = dmode_vec[mtsel_reg] & ~dbg_mode;
    assign wr_tsel   = csr_wen & (csr_waddr == ADDR_MTSEL);
    assign wr_tdata1 = csr_wen & (csr_waddr == ADDR_MTDATA1) & ~lock;
    assign wr_tdata2 = csr_wen & (csr_waddr == ADDR_MTDATA2) & ~lock;

    // Matches never count while the core is in debug mode.
    assign raw = trigger_match_m & {NTRIG{trigger_valid_m & ~dbg_mode}};

    // mtsel is WARL: out-of-range writes leave the selection untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtsel_reg <= 2'b00;
        end else if (wr_tsel && (csr_wdata[31:2] == 30'd0)) begin
            mtsel_reg <= csr_wdata[1:0];
        end
    end

    generate
        for (genvar gi = 0; gi < NTRIG; gi++) begin : g_trig
            localparam int  PAIR     = gi - (gi % 2);
            localparam int  MATE     = gi ^ 1;
            localparam logic CHAINABLE = ((gi % 2) == 0);

            logic        sel;
            logic        dmode_new;
            logic        dmode_reg, hit_reg, select_reg, action_reg, chain_reg;
            logic        match_reg, m_reg, execute_reg, store_reg, load_reg;
            logic [31:0] tdata2_reg;

            assign sel       = (mtsel_reg == 2'(gi));
            assign dmode_new = csr_wdata[27] & dbg_mode;

            // mtdata1 fields; a software write overrides everything except a same-cycle hit.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dmode_reg   <= 1'b0;
                    hit_reg     <= 1'b0;
                    select_reg  <= 1'b0;
                    action_reg  <= 1'b0;
                    chain_reg   <= 1'b0;
                    match_reg   <= 1'b0;
                    m_reg       <= 1'b0;
                    execute_reg <= 1'b0;
                    store_reg   <= 1'b0;
                    load_reg    <= 1'b0;
                    tdata2_reg  <= 32'd0;
                end else begin
                    if (wr_tdata1 && sel) begin
                        dmode_reg   <= dmode_new;
                        hit_reg     <= csr_wdata[20] | fire[gi];
                        select_reg  <= csr_wdata[19];
                        action_reg  <= csr_wdata[12] & dmode_new;
                        chain_reg   <= csr_wdata[11] & CHAINABLE;
                        match_reg   <= csr_wdata[7];
                        m_reg       <= csr_wdata[6];
                        execute_reg <= csr_wdata[2];
                        store_reg   <= csr_wdata[1];
                        load_reg    <= csr_wdata[0];
                    end else if (fire[gi]) begin
                        hit_reg <= 1'b1;
                    end
                    if (wr_tdata2 && sel) begin
                        tdata2_reg <= csr_wdata;
                    end
                end
            end

            assign dmode_vec[gi]   = dmode_reg;
            assign hit_vec[gi]     = hit_reg;
            assign select_vec[gi]  = select_reg;
            assign action_vec[gi]  = action_reg;
            assign chain_vec[gi]   = chain_reg;
            assign match_vec[gi]   = match_reg;
            assign m_vec[gi]       = m_reg;
            assign execute_vec[gi] = execute_reg;
            assign store_vec[gi]   = store_reg;
            assign load_vec[gi]    = load_reg;
            assign tdata2_vec[gi]  = tdata2_reg;

            // A chained pair fires only when both halves match together.
            assign fire[gi] = raw[gi] & (~chain_vec[PAIR] | raw[MATE]);

            assign trigger_pkt_any[gi].select  = select_reg;
            assign trigger_pkt_any[gi].match   = match_reg;
            assign trigger_pkt_any[gi].store   = store_reg;
            assign trigger_pkt_any[gi].load    = load_reg;
            assign trigger_pkt_any[gi].execute = execute_reg;
            assign trigger_pkt_any[gi].m       = m_reg & ~dbg_mode & (mstatus_mie | action_reg);
            assign trigger_pkt_any[gi].tdata2  = tdata2_reg;
        end
    endgenerate

    assign dbg_next = |(fire & action_vec);
    assign exc_next = |(fire & ~action_vec) & ~dbg_next;

    // One-cycle request pulses for every firing cycle; halt takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trigger_hit_vec_r <= '0;
            trigger_dbg_r     <= 1'b0;
            trigger_exc_r     <= 1'b0;
        end else begin
            trigger_hit_vec_r <= fire;
            trigger_dbg_r     <= dbg_next;
            trigger_exc_r     <= exc_next;
        end
    end

    // Combinational CSR read port, zero for any non-trigger address.
    always_comb begin
        csr_rdata = 32'd0;
        case (csr_raddr)
            ADDR_MTSEL:   csr_rdata = {30'd0, mtsel_reg};
            ADDR_MTDATA1: csr_rdata = {4'h2, dmode_vec[mtsel_reg], 6'(MASKMAX),
                                       hit_vec[mtsel_reg], select_vec[mtsel_reg], 6'd0,
                                       action_vec[mtsel_reg], chain_vec[mtsel_reg], 3'd0,
                                       match_vec[mtsel_reg], m_vec[mtsel_reg], 3'd0,
                                       execute_vec[mtsel_reg], store_vec[mtsel_reg],
                                       load_vec[mtsel_reg]};
            ADDR_MTDATA2: csr_rdata = tdata2_vec[mtsel_reg];
            default:      csr_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_eb1_dec_trigger_csr.sv
// Directed self-checking bench for eb1_dec_trigger_csr.
module tb_eb1_dec_trigger_csr;
    import eb1_trig_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   dbg_mode = 1'b0;
    logic                   mstatus_mie = 1'b0;
    logic                   csr_wen = 1'b0;
    logic [11:0]            csr_waddr = 12'd0;
    logic [31:0]            csr_wdata = 32'd0;
    logic [11:0]            csr_raddr = 12'd0;
    logic [31:0]            csr_rdata;
    logic [3:0]             trigger_match_m = 4'd0;
    logic                   trigger_valid_m = 1'b0;
    eb1_trigger_pkt_t [3:0] trigger_pkt_any;
    logic [3:0]             trigger_hit_vec_r;
    logic                   trigger_dbg_r;
    logic                   trigger_exc_r;

    int n_cmp = 0;
    int n_err = 0;

    eb1_dec_trigger_csr #(.NTRIG(4), .MASKMAX(31)) dut (
        .clk               (clk),
        .rst               (rst),
        .dbg_mode          (dbg_mode),
        .mstatus_mie       (mstatus_mie),
        .csr_wen           (csr_wen),
        .csr_waddr         (csr_waddr),
        .csr_wdata         (csr_wdata),
        .csr_raddr         (csr_raddr),
        .csr_rdata         (csr_rdata),
        .trigger_match_m   (trigger_match_m),
        .trigger_valid_m   (trigger_valid_m),
        .trigger_pkt_any   (trigger_pkt_any),
        .trigger_hit_vec_r (trigger_hit_vec_r),
        .trigger_dbg_r     (trigger_dbg_r),
        .trigger_exc_r     (trigger_exc_r)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic chk_rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        csr_raddr = addr;
        #1;
        check(tag, {32'd0, csr_rdata}, {32'd0, exp});
    endtask

    // All stimulus tasks start and end just after a falling edge.
    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        csr_wen   = 1'b1;
        csr_waddr = addr;
        csr_wdata = data;
        @(posedge clk);
        @(negedge clk);
        csr_wen = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] m);
        trigger_match_m = m;
        trigger_valid_m = 1'b1;
        @(posedge clk);
        @(negedge clk);
        trigger_match_m = 4'd0;
        trigger_valid_m = 1'b0;
    endtask

    task automatic wr_fire(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] m);
        csr_wen         = 1'b1;
        csr_waddr       = addr;
        csr_wdata       = data;
        trigger_match_m = m;
        trigger_valid_m = 1'b1;
        @(posedge clk);
        @(negedge clk);
        csr_wen         = 1'b0;
        trigger_match_m = 4'd0;
        trigger_valid_m = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // T1: reset state
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) check($sformatf("rst_pkt%0d", i), {26'd0, trigger_pkt_any[i]}, 64'd0);
        chk_rd("rst_mtdata1", 12'h7A1, 32'h23E00000);
        check("rst_hit_vec", {60'd0, trigger_hit_vec_r}, 64'd0);
        check("rst_dbg", {63'd0, trigger_dbg_r}, 64'd0);
        check("rst_exc", {63'd0, trigger_exc_r}, 64'd0);
        rst = 1'b0;
        tick();

        // T2: program trigger 2 and fire it
        wr(12'h7A0, 32'd2);
        wr(12'h7A1, 32'h00000042);
        wr(12'h7A2, 32'h00001000);
        mstatus_mie = 1'b1;
        chk_rd("t2_mtdata1", 12'h7A1, 32'h23E00042);
        chk_rd("t2_mtdata2", 12'h7A2, 32'h00001000);
        check("t2_pkt2", {26'd0, trigger_pkt_any[2]}, {26'd0, 6'b001001, 32'h00001000});
        mstatus_mie = 1'b0;
        #1 check("t2_pkt2_m_nomie", {63'd0, trigger_pkt_any[2].m}, 64'd0);
        mstatus_mie = 1'b1;
        pulse(4'b0100);
        check("t2_hit_vec", {60'd0, trigger_hit_vec_r}, 64'h4);
        check("t2_exc", {63'd0, trigger_exc_r}, 64'd1);
        check("t2_dbg", {63'd0, trigger_dbg_r}, 64'd0);
        chk_rd("t2_mtdata1_hit", 12'h7A1, 32'h23F00042);
        tick();
        check("t2_hit_vec_end", {60'd0, trigger_hit_vec_r}, 64'd0);
        check("t2_exc_end", {63'd0, trigger_exc_r}, 64'd0);

        // T3: chain pair 0/1
        wr(12'h7A0, 32'd0);
        wr(12'h7A1, 32'h00000800);
        chk_rd("t3_mtdata1", 12'h7A1, 32'h23E00800);
        pulse(4'b0001);
        check("t3_half_hit_vec", {60'd0, trigger_hit_vec_r}, 64'd0);
        check("t3_half_exc", {63'd0, trigger_exc_r}, 64'd0);
        chk_rd("t3_half_nohit", 12'h7A1, 32'h23E00800);
        trigger_match_m = 4'b0011;
        trigger_valid_m = 1'b1;
        tick();
        check("t3_pair_hit_vec", {60'd0, trigger_hit_vec_r}, 64'h3);
        check("t3_pair_exc", {63'd0, trigger_exc_r}, 64'd1);
        tick();
        check("t3_b2b_hit_vec", {60'd0, trigger_hit_vec_r}, 64'h3);
        trigger_match_m = 4'd0;
        trigger_valid_m = 1'b0;
        tick();
        check("t3_b2b_end", {60'd0, trigger_hit_vec_r}, 64'd0);
        chk_rd("t3_mtdata1_hit", 12'h7A1, 32'h23F00800);
        dbg_mode = 1'b1;
        pulse(4'b0011);
        check("t3_dbgmode_nofire", {60'd0, trigger_hit_vec_r}, 64'd0);
        dbg_mode = 1'b0;

        // T4: dmode/action only writable in debug, then locked
        wr(12'h7A0, 32'd1);
        wr(12'h7A1, 32'h08001040);
        chk_rd("t4_nodbg_dmode", 12'h7A1, 32'h23E00040);
        dbg_mode = 1'b1;
        wr(12'h7A1, 32'h08001040);
        chk_rd("t4_dbg_dmode", 12'h7A1, 32'h2BE01040);
        #1 check("t4_pkt1_m_dbg", {63'd0, trigger_pkt_any[1].m}, 64'd0);
        dbg_mode = 1'b0;
        mstatus_mie = 1'b0;
        #1 check("t4_pkt1_m_action", {63'd0, trigger_pkt_any[1].m}, 64'd1);
        mstatus_mie = 1'b1;
        wr(12'h7A2, 32'h0000FFFF);
        chk_rd("t4_locked_mtdata2", 12'h7A2, 32'h00000000);
        wr(12'h7A1, 32'h00000000);
        chk_rd("t4_locked_mtdata1", 12'h7A1, 32'h2BE01040);
        pulse(4'b0011);
        check("t4_hit_vec", {60'd0, trigger_hit_vec_r}, 64'h3);
        check("t4_dbg", {63'd0, trigger_dbg_r}, 64'd1);
        check("t4_exc_suppressed", {63'd0, trigger_exc_r}, 64'd0);
        chk_rd("t4_mtdata1_hit", 12'h7A1, 32'h2BF01040);

        // T5: WARL mtsel and hardwired chain on trigger 3
        wr(12'h7A0, 32'd5);
        chk_rd("t5_mtsel_warl", 12'h7A0, 32'd1);
        wr(12'h7A0, 32'd3);
        chk_rd("t5_mtsel3", 12'h7A0, 32'd3);
        wr(12'h7A1, 32'h00000800);
        chk_rd("t5_chain3_zero", 12'h7A1, 32'h23E00000);

        // T6: fire wins against a same-cycle software hit clear
        wr(12'h7A0, 32'd1);
        dbg_mode = 1'b1;
        wr(12'h7A1, 32'h00000000);
        dbg_mode = 1'b0;
        chk_rd("t6_unlocked", 12'h7A1, 32'h23E00000);
        wr_fire(12'h7A1, 32'h00000040, 4'b0011);
        check("t6_hit_vec", {60'd0, trigger_hit_vec_r}, 64'h3);
        check("t6_exc", {63'd0, trigger_exc_r}, 64'd1);
        check("t6_dbg", {63'd0, trigger_dbg_r}, 64'd0);
        chk_rd("t6_hit_kept", 12'h7A1, 32'h23F00040);
        wr(12'h7A1, 32'h00000040);
        chk_rd("t6_hit_cleared", 12'h7A1, 32'h23E00040);

        // Asynchronous reset in the middle of a firing pulse
        trigger_match_m = 4'b0011;
        trigger_valid_m = 1'b1;
        @(posedge clk);
        #2;
        check("ar_pre_hit_vec", {60'd0, trigger_hit_vec_r}, 64'h3);
        rst = 1'b1;
        #1;
        check("ar_hit_vec", {60'd0, trigger_hit_vec_r}, 64'd0);
        check("ar_exc", {63'd0, trigger_exc_r}, 64'd0);
        check("ar_pkt1", {26'd0, trigger_pkt_any[1]}, 64'd0);
        chk_rd("ar_mtsel", 12'h7A0, 32'd0);
        chk_rd("ar_mtdata1", 12'h7A1, 32'h23E00000);
        trigger_match_m = 4'd0;
        trigger_valid_m = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
